child_slot_sequencer: RTL and testbench

//  Sequences the five child instances beneath a generated root module, one after another.

---
 rtl/slot_seq_pkg.sv | 15 +
 rtl/slot_timeout_ctr.sv | 37 +++
 rtl/child_slot_sequencer.sv | 150 +++++++++++++++
 tb/tb_child_slot_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/slot_seq_pkg.sv
// Shared types and constants for the child slot sequencer.
// Imported by the sequencer top level.
package slot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } seq_state_t;

    localparam int unsigned SLOT_IDX_W = 4;

endpackage

// File: rtl/slot_timeout_ctr.sv
// Per-slot timeout down-counter: loaded when a slot is started, decremented while waiting.
// Holds at zero rather than wrapping.
module slot_timeout_ctr #(
    parameter int unsigned TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMO_W'(1);
        end
    end

    // High in the cycle whose decrement brings the count to zero.
    assign zero_o = (cnt_q == TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/child_slot_sequencer.sv
// Starts each enabled child slot in index order, waits for its done, and flags the
// first slot that times out. All outputs are registered.
module child_slot_sequencer
    import slot_seq_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 5,
    parameter int unsigned TMO_W      = 8,
    parameter int unsigned TMO_CYCLES = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic [NUM_SLOTS-1:0] slot_en,
    output logic [NUM_SLOTS-1:0] slot_start,
    input  logic [NUM_SLOTS-1:0] slot_done,
    output logic                 busy,
    output logic                 run_done,
    output logic                 run_err,
    output logic [3:0]           err_slot
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS + 1);

    seq_state_t                state_q, state_d;
    logic [NUM_SLOTS-1:0]      mask_q, mask_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_SLOTS-1:0]      slot_start_q, slot_start_d;
    logic                      busy_q, busy_d;
    logic                      run_done_q, run_done_d;
    logic                      run_err_q, run_err_d;
    logic [SLOT_IDX_W-1:0]     err_slot_q, err_slot_d;

    logic [NUM_SLOTS-1:0]      cur_sel;
    logic                      cur_en;
    logic                      cur_done;
    logic                      tmo_load;
    logic                      tmo_en;
    logic                      tmo_zero;

    // All-zero once idx has walked past the last slot.
    assign cur_sel  = NUM_SLOTS'(1) << idx_q;
    assign cur_en   = |(mask_q & cur_sel);
    assign cur_done = |(slot_done & cur_sel);

    slot_timeout_ctr #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmo_load),
        .load_val_i (TMO_W'(TMO_CYCLES)),
        .en_i       (tmo_en),
        .zero_o     (tmo_zero)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        slot_start_d = '0;
        busy_d       = busy_q;
        run_done_d   = 1'b0;
        run_err_d    = run_err_q;
        err_slot_d   = err_slot_q;
        tmo_load     = 1'b0;
        tmo_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = SCAN;
                    mask_d     = slot_en;
                    idx_d      = '0;
                    run_err_d  = 1'b0;
                    err_slot_d = '0;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                if (idx_q == IDX_W'(NUM_SLOTS)) begin
                    state_d    = FINISH;
                    run_done_d = 1'b1;
                end else if (!cur_en) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    // Registered strobe lands in the ISSUE cycle.
                    state_d      = ISSUE;
                    slot_start_d = cur_sel;
                end
            end
            ISSUE: begin
                tmo_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cur_done) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_zero) begin
                        run_err_d = 1'b1;
                        if (!run_err_q) begin
                            err_slot_d = SLOT_IDX_W'(idx_q);
                        end
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            slot_start_q <= '0;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            run_err_q    <= 1'b0;
            err_slot_q   <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            slot_start_q <= slot_start_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            run_err_q    <= run_err_d;
            err_slot_q   <= err_slot_d;
        end
    end

    assign slot_start = slot_start_q;
    assign busy       = busy_q;
    assign run_done   = run_done_q;
    assign run_err    = run_err_q;
    assign err_slot   = err_slot_q;

endmodule

// File: tb/tb_child_slot_sequencer.sv
// Randomised bench for child_slot_sequencer: a timeline model predicts every start strobe,
// busy window, run_done pulse and error report per run.
module tb_child_slot_sequencer;

    localparam int N = 5;
    localparam int T = 200;
    localparam int NEVER = -1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [N-1:0] slot_en = '0;
    logic [N-1:0] slot_start;
    logic [N-1:0] slot_done = '0;
    logic         busy;
    logic         run_done;
    logic         run_err;
    logic [3:0]   err_slot;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    child_slot_sequencer #(
        .NUM_SLOTS  (N),
        .TMO_W      (8),
        .TMO_CYCLES (T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .slot_en    (slot_en),
        .slot_start (slot_start),
        .slot_done  (slot_done),
        .busy       (busy),
        .run_done   (run_done),
        .run_err    (run_err),
        .err_slot   (err_slot)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".slot_start"}, 32'(slot_start), 32'd0);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".run_done"},   32'(run_done),   32'd0);
        check({tag, ".run_err"},    32'(run_err),    32'd0);
        check({tag, ".err_slot"},   32'(err_slot),   32'd0);
    endtask

    // d[i]: cycles from slot i's start to its done pulse; NEVER = child stays silent.
    // abort_slot >= 0 asserts reset three cycles after that slot is started.
    task automatic run(input logic [N-1:0] mask, input int d[N], input int abort_slot);
        int ex_start[N];
        int ex_end[N];
        int act_start[N];
        int t, s, c0, rd, err_from, es, abort_at;
        bit err;
        logic [N-1:0] exp_st;

        // Timeline: skipped slot = 1 cycle; enabled slot = SCAN, ISSUE(start), then up to
        // T waiting cycles; the run closes with SCAN past the end plus FINISH.
        c0 = cyc;
        t = c0 + 1;
        err = 1'b0;
        err_from = 1 << 30;
        es = 0;
        for (int i = 0; i < N; i++) begin
            ex_start[i] = -1;
            ex_end[i] = -1;
            act_start[i] = -1;
            if (!mask[i]) begin
                t++;
            end else begin
                s = t + 1;
                ex_start[i] = s;
                if (d[i] >= 1 && d[i] <= T) begin
                    ex_end[i] = s + d[i];
                    t = s + d[i] + 1;
                end else begin
                    ex_end[i] = s + T;
                    t = s + T + 1;
                    if (!err) begin
                        err = 1'b1;
                        err_from = s + T + 1;
                        es = i;
                    end
                end
            end
        end
        rd = t + 1;
        abort_at = (abort_slot >= 0) ? ex_start[abort_slot] + 3 : -1;

        go = 1'b1;
        slot_en = mask;
        slot_done = '0;
        while (cyc <= rd + 1) begin
            @(negedge clk);
            exp_st = '0;
            for (int i = 0; i < N; i++) begin
                if (ex_start[i] == cyc) exp_st[i] = 1'b1;
            end
            check("slot_start", 32'(slot_start), 32'(exp_st));
            check("run_done", 32'(run_done), 32'(cyc == rd));
            check("busy", 32'(busy), 32'(cyc > c0 && cyc <= rd));
            if (cyc > c0) begin
                check("run_err", 32'(run_err), 32'(cyc >= err_from));
                check("err_slot", 32'(err_slot), (cyc >= err_from) ? 32'(es) : 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (slot_start[i]) act_start[i] = cyc;
            end

            next_cycle();
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("mid_reset");
                go = 1'b0;
                slot_done = '0;
                next_cycle();
                rst_n = 1'b1;
                return;
            end
            // go inside the run must be ignored; mask changes must not leak in.
            go = (cyc <= rd) ? 1'($urandom_range(0, 1)) : 1'b0;
            slot_en = N'($urandom);
            for (int i = 0; i < N; i++) begin
                slot_done[i] = (d[i] != NEVER) && (act_start[i] >= 0)
                               && (cyc == act_start[i] + d[i]);
                if (!(ex_start[i] >= 0 && cyc > ex_start[i] && cyc <= ex_end[i])) begin
                    slot_done[i] = slot_done[i] | ($urandom_range(0, 3) == 0);
                end
            end
        end
        go = 1'b0;
        slot_done = '0;
    endtask

    initial begin
        int dly[N];
        int r;
        logic [N-1:0] m;

        rst_n = 1'b0;
        repeat (3) next_cycle();
        check_all_zero("reset");
        rst_n = 1'b1;
        next_cycle();

        dly = '{2, 2, 2, 2, 2};
        run(5'b11111, dly, -1);
        run(5'b10100, dly, -1);
        dly = '{2, NEVER, 2, 2, 2};
        run(5'b11111, dly, -1);
        dly = '{1, 1, 1, T, 1};
        run(5'b11111, dly, -1);
        dly = '{1, 1, 1, NEVER, NEVER};
        run(5'b11111, dly, -1);
        dly = '{0, 1, T + 1, 3, 1};
        run(5'b11111, dly, -1);
        dly = '{1, 1, 1, 1, 1};
        run(5'b00000, dly, -1);
        dly = '{1, 2, NEVER, 1, 1};
        run(5'b11111, dly, 2);
        dly = '{3, 1, 2, 1, 2};
        run(5'b11111, dly, -1);

        for (int k = 0; k < 12; k++) begin
            m = N'($urandom);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    dly[i] = NEVER;
                    2:       dly[i] = 0;
                    3:       dly[i] = T;
                    4:       dly[i] = T + 1;
                    default: dly[i] = $urandom_range(1, 6);
                endcase
            end
            run(m, dly, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
